// File: rtl/ram_ctrl_pkg.sv
// Shared types and default dimensions for the paged-RAM controller.
// The RAM is 32 pages of 256 words of 16 bits; a burst moves one page.
package ram_ctrl_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_PAGE_BITS  = 5;
   localparam int unsigned DEF_WORD_BITS  = 8;
   localparam int unsigned BURST_LAST     = (1 << DEF_WORD_BITS) - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } gnt_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter. The grant is combinational; the
// last-grant pointer only moves when a grant is actually issued.
module rr_arbiter_2
   import ram_ctrl_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic wr_req_i,
   input  logic rd_req_i,
   output logic wr_gnt_o,
   output logic rd_gnt_o
);

   gnt_e last_q, last_d;

   always_comb begin
      wr_gnt_o = 1'b0;
      rd_gnt_o = 1'b0;
      last_d   = last_q;
      if (en_i) begin
         // On contention the side that did not win last time gets the grant.
         if (wr_req_i && (!rd_req_i || last_q == GNT_RD)) begin
            wr_gnt_o = 1'b1;
            last_d   = GNT_WR;
         end else if (rd_req_i) begin
            rd_gnt_o = 1'b1;
            last_d   = GNT_RD;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q <= GNT_RD;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ram_page_controller.sv
// Request/grant sequencer sharing a paged RAM between one writer and one
// reader; each grant moves a full page as a burst of consecutive words.
module ram_page_controller
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned PAGE_BITS  = DEF_PAGE_BITS,
   parameter int unsigned WORD_BITS  = DEF_WORD_BITS
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_req,
   input  logic [PAGE_BITS-1:0]  wr_page,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_grant,
   output logic                  wr_ready,
   output logic                  wr_done,
   input  logic                  rd_req,
   input  logic [PAGE_BITS-1:0]  rd_page,
   output logic                  rd_grant,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [PAGE_BITS-1:0]  mem_page,
   output logic [WORD_BITS-1:0]  mem_word,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   localparam logic [WORD_BITS-1:0] LAST_WORD = '1;
   localparam logic [WORD_BITS-1:0] WORD_ONE  = 1;

   state_e                 state_q, state_d;
   logic [WORD_BITS-1:0]   word_cnt_q, word_cnt_d;
   logic [WORD_BITS-1:0]   hold_word_q, hold_word_d;
   logic [PAGE_BITS-1:0]   page_q, page_d;
   logic                   rd_valid_q, rd_last_q, wr_done_q;
   logic                   wr_gnt, rd_gnt;
   logic                   at_last;
   logic                   in_burst;

   rr_arbiter_2 u_arb (
      .clk_i    (clock),
      .rst_ni   (reset),
      .en_i     (state_q == IDLE),
      .wr_req_i (wr_req),
      .rd_req_i (rd_req),
      .wr_gnt_o (wr_gnt),
      .rd_gnt_o (rd_gnt)
   );

   assign at_last = (word_cnt_q == LAST_WORD);

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      page_d      = page_q;
      hold_word_d = hold_word_q;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_gnt) begin
               state_d    = WRITE;
               page_d     = wr_page;
               word_cnt_d = '0;
            end else if (rd_gnt) begin
               state_d    = READ;
               page_d     = rd_page;
               word_cnt_d = '0;
            end
         end
         WRITE: begin
            if (wr_valid) begin
               mem_we      = 1'b1;
               hold_word_d = word_cnt_q;
               word_cnt_d  = word_cnt_q + WORD_ONE;
               if (at_last) state_d = IDLE;
            end
         end
         READ: begin
            mem_re      = 1'b1;
            hold_word_d = word_cnt_q;
            word_cnt_d  = word_cnt_q + WORD_ONE;
            if (at_last) state_d = DRAIN;
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         hold_word_q <= '0;
         page_q      <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         wr_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         hold_word_q <= hold_word_d;
         page_q      <= page_d;
         rd_valid_q  <= mem_re;
         rd_last_q   <= mem_re && at_last;
         wr_done_q   <= mem_we && at_last;
      end
   end

   // Outside a burst the address bus keeps the last issued word, not the
   // wrapped counter.
   assign in_burst  = (state_q == WRITE) || (state_q == READ);
   assign mem_word  = in_burst ? word_cnt_q : hold_word_q;
   assign mem_page  = page_q;
   assign mem_wdata = (state_q == WRITE) ? wr_data : '0;

   assign wr_grant  = (state_q == WRITE);
   assign wr_ready  = (state_q == WRITE);
   assign wr_done   = wr_done_q;
   assign rd_grant  = (state_q == READ) || (state_q == DRAIN);
   assign rd_data   = mem_rdata;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_page_controller.sv
// Bench for ram_page_controller: behavioural RAM plus a page-content
// scoreboard and cycle-by-cycle burst timing expectations.
module tb_ram_page_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_req, wr_valid, rd_req;
   logic [4:0]  wr_page, rd_page;
   logic [15:0] wr_data;
   logic        wr_grant, wr_ready, wr_done;
   logic        rd_grant, rd_valid, rd_last;
   logic [15:0] rd_data;
   logic        mem_we, mem_re;
   logic [4:0]  mem_page;
   logic [7:0]  mem_word;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] ram     [0:8191];
   logic [15:0] exp_mem [0:31][0:255];

   always #5 clock = ~clock;

   ram_page_controller #(
      .DATA_WIDTH (16),
      .PAGE_BITS  (5),
      .WORD_BITS  (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .wr_req    (wr_req),
      .wr_page   (wr_page),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_grant  (wr_grant),
      .wr_ready  (wr_ready),
      .wr_done   (wr_done),
      .rd_req    (rd_req),
      .rd_page   (rd_page),
      .rd_grant  (rd_grant),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_last   (rd_last),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_page  (mem_page),
      .mem_word  (mem_word),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // RAM with one-cycle read latency.
   always @(posedge clock) begin
      if (mem_we) ram[{mem_page, mem_word}] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[{mem_page, mem_word}];
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset();
      reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
      wr_page = '0; rd_page = '0; wr_data = '0;
      repeat (3) @(posedge clock);
      #1;
      wr_req = 1'b1; wr_valid = 1'b1; wr_data = 16'hBEEF; rd_req = 1'b1;
      @(negedge clock);
      checks++;
      if ({wr_grant, wr_ready, wr_done, rd_grant, rd_valid, rd_last, mem_we, mem_re, busy} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b exp 000000000",
                  {wr_grant, wr_ready, wr_done, rd_grant, rd_valid, rd_last, mem_we, mem_re, busy});
      end
      checks++;
      if ({mem_page, mem_word, mem_wdata} !== 29'b0) begin
         errors++;
         $display("FAIL reset_bus got page %0h word %0h wdata %0h exp 0", mem_page, mem_word, mem_wdata);
      end
      @(posedge clock); #1;
      wr_req = 1'b0; rd_req = 1'b0; wr_valid = 1'b0; reset = 1'b1;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_release_busy got %b exp 0", busy);
      end
   endtask

   // mode 0: data=index, valid always; 1: valid every other cycle; 2: random.
   task automatic do_write(input logic [4:0] pg, input int mode, input string tag);
      logic [15:0] data [256];
      int idx, last_t, n_done, t, nvalid, model_last, exp_last;
      logic exp_we, exp_g, exp_done;
      for (int i = 0; i < 256; i++) data[i] = (mode == 0) ? 16'(i) : 16'($urandom);
      idx = 0; last_t = -1; n_done = 0; t = 0; nvalid = 0; model_last = -1;
      @(posedge clock); #1;
      wr_req = 1'b1; wr_page = pg; wr_valid = 1'b1; wr_data = data[0];
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s grant_cycle_busy got %b exp 0", tag, busy); end
      while (t < 1500 && !(last_t >= 0 && t > last_t)) begin
         t++;
         @(posedge clock); #1;
         wr_req  = 1'b0;
         wr_page = 5'($urandom);
         case (mode)
            0:       wr_valid = 1'b1;
            1:       wr_valid = ((t - 1) % 2 == 0);
            default: wr_valid = 1'($urandom_range(0, 1));
         endcase
         wr_data = (idx < 256) ? data[idx] : 16'($urandom);
         if (wr_valid && nvalid < 256) begin
            nvalid++;
            if (nvalid == 256) model_last = t;
         end
         @(negedge clock);
         exp_g    = (idx < 256);
         exp_we   = wr_valid && exp_g;
         exp_done = (last_t >= 0) && (t == last_t + 1);
         checks++;
         if ({wr_grant, wr_ready} !== {exp_g, exp_g}) begin
            errors++; $display("FAIL %s grant t=%0d got %b%b exp %b", tag, t, wr_grant, wr_ready, exp_g);
         end
         checks++;
         if (mem_we !== exp_we || mem_re !== 1'b0) begin
            errors++; $display("FAIL %s strobe t=%0d got we=%b re=%b exp we=%b re=0", tag, t, mem_we, mem_re, exp_we);
         end
         checks++;
         if (wr_done !== exp_done) begin
            errors++; $display("FAIL %s wr_done t=%0d got %b exp %b", tag, t, wr_done, exp_done);
         end
         if (wr_done === 1'b1) n_done++;
         if (mem_we === 1'b1 && exp_we) begin
            checks++;
            if (mem_word !== 8'(idx) || mem_page !== pg || mem_wdata !== data[idx]) begin
               errors++;
               $display("FAIL %s write_beat t=%0d got page %0d word %0d data %h exp page %0d word %0d data %h",
                        tag, t, mem_page, mem_word, mem_wdata, pg, idx, data[idx]);
            end
            exp_mem[pg][idx] = data[idx];
            idx++;
            if (idx == 256) last_t = t;
         end
         if (exp_done) begin
            checks++;
            if (busy !== 1'b0 || mem_word !== 8'hFF || mem_page !== pg) begin
               errors++;
               $display("FAIL %s after_burst got busy %b word %0d page %0d exp 0 255 %0d", tag, busy, mem_word, mem_page, pg);
            end
         end
      end
      exp_last = (mode == 0) ? 256 : (mode == 1) ? 511 : model_last;
      checks++;
      if (idx != 256 || last_t != exp_last) begin
         errors++; $display("FAIL %s burst_len got %0d words last_cycle %0d exp 256 %0d", tag, idx, last_t, exp_last);
      end
      checks++;
      if (n_done != 1) begin errors++; $display("FAIL %s done_count got %0d exp 1", tag, n_done); end
      @(posedge clock); #1;
      wr_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (wr_done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL %s done_width got done %b busy %b exp 0 0", tag, wr_done, busy);
      end
   endtask

   task automatic do_read(input logic [4:0] pg, input int drop_at, input string tag);
      int nvalid;
      logic exp_re, exp_v, exp_l, exp_b;
      nvalid = 0;
      @(posedge clock); #1;
      rd_req = 1'b1; rd_page = pg;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s grant_cycle_busy got %b exp 0", tag, busy); end
      for (int t = 1; t <= 258; t++) begin
         @(posedge clock); #1;
         if (t > drop_at) rd_req = 1'b0;
         rd_page = 5'($urandom);
         @(negedge clock);
         exp_re = (t <= 256);
         exp_v  = (t >= 2 && t <= 257);
         exp_l  = (t == 257);
         exp_b  = (t <= 257);
         checks++;
         if (mem_re !== exp_re || mem_we !== 1'b0) begin
            errors++; $display("FAIL %s strobe t=%0d got re=%b we=%b exp re=%b we=0", tag, t, mem_re, mem_we, exp_re);
         end
         checks++;
         if ({rd_valid, rd_last, rd_grant, busy} !== {exp_v, exp_l, exp_b, exp_b}) begin
            errors++;
            $display("FAIL %s flags t=%0d got v%b l%b g%b b%b exp v%b l%b g%b b%b", tag, t,
                     rd_valid, rd_last, rd_grant, busy, exp_v, exp_l, exp_b, exp_b);
         end
         if (exp_re || t == 258) begin
            checks++;
            if (mem_word !== (exp_re ? 8'(t - 1) : 8'hFF) || mem_page !== pg) begin
               errors++; $display("FAIL %s addr t=%0d got page %0d word %0d exp page %0d", tag, t, mem_page, mem_word, pg);
            end
         end
         if (exp_v && rd_valid === 1'b1) begin
            nvalid++;
            checks++;
            if (rd_data !== exp_mem[pg][t - 2]) begin
               errors++; $display("FAIL %s rd_data word %0d got %h exp %h", tag, t - 2, rd_data, exp_mem[pg][t - 2]);
            end
         end
      end
      checks++;
      if (nvalid != 256) begin errors++; $display("FAIL %s rd_valid_count got %0d exp 256", tag, nvalid); end
   endtask

   task automatic test_write_page();
      do_write(5'd3, 0, "write_p3");
   endtask

   task automatic test_read_page();
      do_read(5'd3, 0, "read_p3");
   endtask

   task automatic test_stall();
      do_write(5'd11, 1, "stall_p11");
      do_read(5'd11, 0, "stall_readback");
   endtask

   task automatic test_rd_drop();
      do_read(5'd11, 10, "rd_drop");
   endtask

   task automatic test_random_pages();
      for (int i = 0; i < 2; i++) begin
         logic [4:0] pg;
         pg = 5'(16 + $urandom_range(0, 15));
         do_write(pg, 2, "rand_write");
         do_read(pg, $urandom_range(0, 200), "rand_read");
      end
   endtask

   // Both requesters held: expect W, IDLE, R+DRAIN, IDLE, W, IDLE.
   task automatic test_back_to_back();
      byte codes [$];
      int  lens  [$];
      byte exp_codes [6];
      int  exp_lens  [6];
      byte c;
      int  ridx;
      exp_codes[0] = "W"; exp_lens[0] = 256;
      exp_codes[1] = "I"; exp_lens[1] = 1;
      exp_codes[2] = "R"; exp_lens[2] = 257;
      exp_codes[3] = "I"; exp_lens[3] = 1;
      exp_codes[4] = "W"; exp_lens[4] = 256;
      exp_codes[5] = "I"; exp_lens[5] = 1;
      ridx = 0;
      @(posedge clock); #1;
      wr_req = 1'b1; rd_req = 1'b1; wr_page = 5'd9; rd_page = 5'd3; wr_valid = 1'b1;
      wr_data = 16'($urandom);
      @(negedge clock);
      for (int t = 1; t <= 772; t++) begin
         @(posedge clock); #1;
         if (t == 772) begin wr_req = 1'b0; rd_req = 1'b0; end
         wr_data = 16'($urandom);
         @(negedge clock);
         if (wr_grant === 1'b1 && rd_grant === 1'b0 && busy === 1'b1)      c = "W";
         else if (rd_grant === 1'b1 && wr_grant === 1'b0 && busy === 1'b1) c = "R";
         else if (wr_grant === 1'b0 && rd_grant === 1'b0 && busy === 1'b0) c = "I";
         else c = "X";
         if (codes.size() > 0 && codes[$] == c) lens[$] = lens[$] + 1;
         else begin codes.push_back(c); lens.push_back(1); end
         if (rd_valid === 1'b1) begin
            checks++;
            if (rd_data !== exp_mem[3][ridx] || rd_last !== (ridx == 255)) begin
               errors++; $display("FAIL rr_read word %0d got %h last %b exp %h", ridx, rd_data, rd_last, exp_mem[3][ridx]);
            end
            ridx++;
         end
      end
      checks++;
      if (codes.size() != 6) begin errors++; $display("FAIL rr_segments got %0d exp 6", codes.size()); end
      for (int i = 0; i < 6 && i < codes.size(); i++) begin
         checks++;
         if (codes[i] != exp_codes[i] || lens[i] != exp_lens[i]) begin
            errors++;
            $display("FAIL rr_seg%0d got %c x%0d exp %c x%0d", i, codes[i], lens[i], exp_codes[i], exp_lens[i]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      @(posedge clock); #1;
      wr_req = 1'b1; wr_page = 5'd5; wr_valid = 1'b1; wr_data = 16'h5000;
      @(negedge clock);
      for (int t = 1; t <= 101; t++) begin
         @(posedge clock); #1;
         wr_req  = 1'b0;
         wr_data = 16'h5000 + 16'(t - 1);
         if (t == 101) reset = 1'b0;
         @(negedge clock);
         if (t == 101) begin
            checks++;
            if (mem_word !== 8'd100 || mem_we !== 1'b1) begin
               errors++; $display("FAIL rst_mid_word got word %0d we %b exp 100 1", mem_word, mem_we);
            end
         end
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({wr_grant, wr_ready, wr_done, rd_grant, rd_valid, rd_last, mem_we, mem_re, busy} !== 9'b0 ||
          {mem_page, mem_word, mem_wdata} !== 29'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs got ctrl %b page %0d word %0d wdata %h exp all 0",
                  {wr_grant, wr_ready, wr_done, rd_grant, rd_valid, rd_last, mem_we, mem_re, busy},
                  mem_page, mem_word, mem_wdata);
      end
      checks++;
      if (rd_data !== mem_rdata) begin
         errors++; $display("FAIL rst_mid_rd_data got %h exp %h", rd_data, mem_rdata);
      end
      wr_valid = 1'b0;
      do_write(5'd5, 2, "rewrite_p5");
      do_read(5'd5, 0, "readback_p5");
   endtask

   initial begin
      test_reset();
      test_write_page();
      test_read_page();
      test_stall();
      test_rd_drop();
      test_back_to_back();
      test_random_pages();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_page_controller.md
# ram_page_controller

Sequencer and arbiter that shares the paged RAM between one write requester and one read requester. The RAM has 32 pages × 256 words × 16 bits. Each granted request moves one whole page as a burst of consecutive words, and the controller drives the RAM's page, word-address and enable lines. It sits between the capture/playback logic and the RAM, and replaces free-running address counters with explicit request/grant bursts.

## Interface
Parameters:
- DATA_WIDTH, 16, word width.
- PAGE_BITS, 5, page address width (32 pages).
- WORD_BITS, 8, word-in-page address width; burst length = 2^WORD_BITS = 256.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low.
- wr_req  in  1  write requester wants a page burst; level, sampled only in IDLE.
- wr_page  in  PAGE_BITS  target page; latched at grant.
- wr_data  in  DATA_WIDTH  write word.
- wr_valid  in  1  wr_data valid this cycle.
- wr_grant  out  1  high for the whole write burst.
- wr_ready  out  1  high in WRITE; a word transfers when wr_valid && wr_ready.
- wr_done  out  1  one-cycle pulse after the final write word.
- rd_req  in  1  read requester wants a page burst; level, sampled only in IDLE.
- rd_page  in  PAGE_BITS  source page; latched at grant.
- rd_grant  out  1  high from grant through the last rd_valid.
- rd_data  out  DATA_WIDTH  equals mem_rdata; qualified by rd_valid.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  with rd_valid on word 2^WORD_BITS−1.
- mem_we  out  1  RAM write strobe.
- mem_re  out  1  RAM read strobe; RAM returns mem_rdata one cycle later.
- mem_page  out  PAGE_BITS  RAM page address.
- mem_word  out  WORD_BITS  RAM word address.
- mem_wdata  out  DATA_WIDTH  RAM write data (= wr_data).
- mem_rdata  in  DATA_WIDTH  RAM read data.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - Only wr_req → WRITE.
  - Only rd_req → READ.
  - Both → round-robin: grant whichever was not granted last. After reset, last = read, so write wins first.
  - On grant, latch the page and clear word_cnt.
- WRITE:
  - On each cycle with wr_valid: mem_we=1, mem_word=word_cnt, word_cnt++.
  - wr_valid low stalls the burst with no RAM write.
  - On the transfer at word_cnt = 2^WORD_BITS−1 → IDLE; wr_done pulses in the next cycle.
- READ:
  - mem_re=1 every cycle with mem_word=word_cnt; word_cnt++.
  - No backpressure.
  - After the issue at word 2^WORD_BITS−1 → DRAIN.
- DRAIN: one cycle for the last read return, then → IDLE.
- rd_valid and rd_last are mem_re and last-issue flags delayed one cycle.
- mem_we and mem_re are never both high. Outside bursts, mem_page and mem_word hold their last values.
- Deasserting a request mid-burst is ignored; the burst always completes. Page inputs are ignored after the grant.
- word_cnt is WORD_BITS wide and wraps to 0 after the last word; it does not carry into the page.
- Reset (reset=0 at an edge) from any state:
  - state=IDLE, word_cnt=0, last-grant=read.
  - All outputs 0, except rd_data, which follows mem_rdata.
  - An in-flight burst is abandoned; pages already written keep their partial contents.

## Timing
- Arbitration: request seen in IDLE at edge N → grant and first strobe from cycle N+1. No request-to-grant combinational path.
- Write burst with wr_valid held high: mem_we high for cycles N+1..N+256; wr_done at N+257, which is also an IDLE cycle.
- Read burst: mem_re for N+1..N+256; rd_valid for N+2..N+257; rd_last at N+257 (DRAIN); IDLE at N+258.
- Minimum gap between bursts: one IDLE cycle.
- wr_done and rd_last are exactly one cycle wide.

## Structure
- Shared package ram_ctrl_pkg holds:
  - the state enum {IDLE, WRITE, READ, DRAIN};
  - the default width constants;
  - BURST_LAST = 2^WORD_BITS−1.
- Sub-module rr_arbiter_2:
  - two-request round-robin;
  - registered last-grant pointer, updated only on an IDLE grant.
- The top level holds the FSM, word counter, page latch and read-valid pipeline.

## Test plan
- Write page 3 with wr_data = word index, wr_valid always high → 256 mem_we, mem_word 0..255, mem_page=3, wr_done at cycle 257 after grant.
- Read page 3 after that write → rd_valid for 256 cycles, rd_data 0..255, rd_last only with 255, busy low at N+258.
- wr_req and rd_req both asserted, held continuously → grants alternate W, R, W, with one IDLE cycle between bursts.
- wr_valid low every other cycle → 511 WRITE cycles, no mem_we on stall cycles, word order preserved.
- rd_req dropped after 10 cycles of READ → still 256 rd_valid.
- reset=0 at word 100 of a write → next cycle IDLE, all outputs 0. A following write to the same page starts at mem_word 0.
